// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS datapath.
// Holds the sequencing-controller state encoding and the zero-register index.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pipe_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load that is currently in EX.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = id_uses_rt && (ex_rt == id_rt);
        // Writes to $zero are discarded, so they can never create a hazard.
        load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: reset-time clear, load-use stalls, branch
// flushes and a halt/drain handshake. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0001,
    parameter int          INIT_CYCLES  = 4,
    parameter int          DRAIN_CYCLES = 4
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int          CNT_W        = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch_taken,
    input  logic        halt_req,
    output logic        pc_we,
    output logic        pc_src,
    output logic        pc_init,
    output logic [31:0] pc_init_val,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        halt_ack,
    output logic [1:0]  state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    pipe_state_t state_q, state_nx;
    logic [15:0] cnt_q, cnt_nx;
    logic        load_use;
    logic        drain_adv;

    load_use_detect u_lud (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    assign state       = state_q;
    assign pc_init_val = RESET_VECTOR;

    always_comb begin
        state_nx     = state_q;
        cnt_nx       = cnt_q;
        drain_adv    = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        pc_init      = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        halt_ack     = 1'b0;

        case (state_q)
            ST_INIT: begin
                pc_init      = 1'b1;
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_q + 16'd1;
                end
            end

            ST_RUN: begin
                if (mem_branch_taken) begin
                    pc_we        = 1'b1;
                    pc_src       = 1'b1;
                    if_id_we     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                end
                if (halt_req) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = '0;
                end
            end

            ST_DRAIN: begin
                // A branch still redirects the PC so resume fetches the target;
                // only a load-use stall holds the drain counter.
                if (mem_branch_taken) begin
                    pc_we        = 1'b1;
                    pc_src       = 1'b1;
                    if_id_we     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    drain_adv    = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                end else begin
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    drain_adv   = 1'b1;
                end
                if (drain_adv) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_nx = ST_HALTED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_q + 16'd1;
                    end
                end
            end

            ST_HALTED: begin
                halt_ack    = 1'b1;
                if_id_flush = 1'b1;
                if (!halt_req) begin
                    state_nx = ST_RUN;
                end
            end

            default: begin
                state_nx = ST_INIT;
                cnt_nx   = '0;
            end
        endcase

        // While reset is held the register may not yet read INIT, so the
        // INIT controls are forced here.
        if (rst) begin
            pc_init      = 1'b1;
            pc_we        = 1'b1;
            pc_src       = 1'b0;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            halt_ack     = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic in_ctl;
    logic stall_ev;
    logic flush_ev;

    assign in_ctl   = !rst && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign flush_ev = in_ctl && mem_branch_taken;
    assign stall_ev = in_ctl && !mem_branch_taken && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-level behavioural model.
// Perf counter checks are compiled in when HAZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam logic [31:0] RV     = 32'h0000_0001;
    localparam int          N_INIT  = 4;
    localparam int          N_DRAIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic        mem_branch_taken = 1'b0, halt_req = 1'b0;
    logic        pc_we, pc_src, pc_init, if_id_we, halt_ack;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [31:0] pc_init_val;
    logic [1:0]  state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: mode 0=INIT 1=RUN 2=DRAIN 3=HALTED; left = cycles still owed.
    int m_mode  = 0;
    int m_left  = N_INIT;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .RESET_VECTOR (RV),
        .INIT_CYCLES  (N_INIT),
        .DRAIN_CYCLES (N_DRAIN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .halt_req         (halt_req),
        .pc_we            (pc_we),
        .pc_src           (pc_src),
        .pc_init          (pc_init),
        .pc_init_val      (pc_init_val),
        .if_id_we         (if_id_we),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_flush     (mem_wb_flush),
        .halt_ack         (halt_ack),
        .state            (state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    function automatic bit ref_hazard();
        if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
        return (ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt);
    endfunction

    // {pc_we,pc_src,pc_init,if_id_we,f_ifid,f_idex,f_exmem,f_memwb,halt_ack,state}
    function automatic logic [10:0] model_out();
        logic [8:0] c;
        bit lu;
        lu = ref_hazard();
        c  = '0;
        if (rst || m_mode == 0)            c = 9'b1_0_1_1_1111_0;
        else if (m_mode == 3)              c = 9'b0_0_0_0_1000_1;
        else if (mem_branch_taken)         c = 9'b1_1_0_1_1110_0;
        else if (lu)                       c = 9'b0_0_0_0_0100_0;
        else if (m_mode == 1)              c = 9'b1_0_0_1_0000_0;
        else                               c = 9'b0_0_0_1_1000_0;
        return {c, 2'(m_mode)};
    endfunction

    function automatic logic [10:0] obs();
        return {pc_we, pc_src, pc_init, if_id_we, if_id_flush, id_ex_flush,
                ex_mem_flush, mem_wb_flush, halt_ack, state};
    endfunction

    task automatic model_clock();
        bit lu;
        lu = ref_hazard();
        if (rst) begin
            m_mode = 0; m_left = N_INIT; m_stall = 0; m_flush = 0;
        end else if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) m_mode = 1;
        end else if (m_mode == 3) begin
            if (!halt_req) m_mode = 1;
        end else begin
            if (mem_branch_taken) m_flush++;
            else if (lu)          m_stall++;
            if (m_mode == 1) begin
                if (halt_req) begin m_mode = 2; m_left = N_DRAIN; end
            end else if (mem_branch_taken || !lu) begin
                m_left--;
                if (m_left == 0) m_mode = 3;
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; mem_branch_taken = 1'b0;
    endtask

    task automatic lu_inputs(input logic [4:0] rt);
        ex_mem_read = 1'b1; ex_rt = rt; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        rst = 1'b1;
        idle_inputs();
        tick();
        #1; exp = model_out(); checks++;
        if (obs() !== exp) begin errors++; $display("FAIL reset_hold got=%b want=%b", obs(), exp); end
        checks++;
        if (pc_init_val !== RV) begin errors++; $display("FAIL pc_init_val got=%h want=%h", pc_init_val, RV); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1; exp = model_out(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL reset_seq cyc=%0d got=%b want=%b", k, obs(), exp); end
            checks++;
            if ((k < 4 && state !== 2'd0) || (k == 4 && (state !== 2'd1 || pc_we !== 1'b1))) begin
                errors++; $display("FAIL reset_run_edge cyc=%0d state=%0d want=%0d", k, state, (k < 4) ? 0 : 1);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [10:0] exp;
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            if (k == 0) lu_inputs(5'd2);
            if (k == 2) lu_inputs(5'd0);
            #1; exp = model_out(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL load_use cyc=%0d got=%b want=%b", k, obs(), exp); end
            checks++;
            if (k == 0 && (pc_we !== 1'b0 || if_id_we !== 1'b0 || id_ex_flush !== 1'b1)) begin
                errors++; $display("FAIL load_use_stall got pc_we=%b if_id_we=%b id_ex_flush=%b want 0 0 1", pc_we, if_id_we, id_ex_flush);
            end else if (k != 0 && pc_we !== 1'b1) begin
                errors++; $display("FAIL load_use_nostall cyc=%0d pc_we=%b want 1", k, pc_we);
            end
            tick();
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, m_stall); end
`endif
    endtask

    task automatic test_branch_lu();
        logic [10:0] exp;
        idle_inputs();
        lu_inputs(5'd2);
        mem_branch_taken = 1'b1;
        #1; exp = model_out(); checks++;
        if (obs() !== exp) begin errors++; $display("FAIL branch_lu got=%b want=%b", obs(), exp); end
        tick();
        idle_inputs();
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (flush_cnt !== 32'(m_flush) || stall_cnt !== 32'(m_stall)) begin
            errors++; $display("FAIL branch_counters got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, m_flush, m_stall);
        end
`endif
    endtask

    // Holds halt_req from a RUN cycle; event 1 = load-use, 2 = branch at cycle 2.
    task automatic test_halt(input int ev, input int want_cycles, input string nm);
        logic [10:0] exp;
        int n;
        bit done;
        done = 1'b0;
        n = 0;
        halt_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            idle_inputs();
            if (k == 2 && ev == 1) lu_inputs(5'd2);
            if (k == 2 && ev == 2) mem_branch_taken = 1'b1;
            #1; exp = model_out(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL %s cyc=%0d got=%b want=%b", nm, k, obs(), exp); end
            if (halt_ack) begin done = 1'b1; n = k; break; end
            tick();
        end
        checks++;
        if (!done || n != want_cycles) begin
            errors++; $display("FAIL %s_latency got=%0d want=%0d acked=%0d", nm, n, want_cycles, done);
        end
        halt_req = 1'b0;
        #1; exp = model_out(); checks++;
        if (obs() !== exp) begin errors++; $display("FAIL %s_release got=%b want=%b", nm, obs(), exp); end
        tick();
        checks++;
        if (halt_ack !== 1'b0 || state !== 2'd1) begin
            errors++; $display("FAIL %s_resume got ack=%b state=%0d want 0 1", nm, halt_ack, state);
        end
    endtask

    task automatic test_reset_drain();
        logic [10:0] exp;
        idle_inputs();
        halt_req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        #1; exp = model_out(); checks++;
        if (obs() !== exp) begin errors++; $display("FAIL rst_drain_hold got=%b want=%b", obs(), exp); end
        tick();
        rst = 1'b0;
        halt_req = 1'b0;
        #1; checks++;
        if (state !== 2'd0 || halt_ack !== 1'b0 || pc_init !== 1'b1) begin
            errors++; $display("FAIL rst_drain got state=%0d ack=%b pc_init=%b want 0 0 1", state, halt_ack, pc_init);
        end
        for (int k = 0; k < N_INIT; k++) tick();
    endtask

    task automatic test_random();
        logic [10:0] exp;
        for (int k = 0; k < 600; k++) begin
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_rt            = 5'($urandom_range(0, 3));
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            id_uses_rt       = 1'($urandom_range(0, 1));
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            rst = ($urandom_range(0, 79) == 0);
            #1; exp = model_out(); checks++;
            if (obs() !== exp) begin errors++; $display("FAIL random cyc=%0d got=%b want=%b", k, obs(), exp); end
`ifdef HAZ_PERF_CNT_EN
            checks++;
            if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin
                errors++; $display("FAIL random_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", k, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_halt(0, N_DRAIN + 1, "halt");
        test_halt(1, N_DRAIN + 2, "halt_lu");
        test_halt(2, N_DRAIN + 1, "halt_br");
        test_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS Datapath. It generates PC write/select and per-stage hold/flush controls for IF_ID, ID_EX, EX_MEM and MEM_WB. It covers four cases: the reset-time pipeline clear, load-use stalls, flushing after a taken branch resolved in MEM, and a halt/drain handshake for debug. It replaces the testbench-forced register clears and PC initialisation with real hardware sequencing.

## Interface
- RESET_VECTOR, 32'h0000_0001, PC value loaded during INIT
- INIT_CYCLES, 4, cycles of full-pipeline flush after reset (≥1)
- DRAIN_CYCLES, 4, bubble cycles needed to retire in-flight instructions on halt (≥1)
- CNT_W, 32, perf counter width (only with HAZ_PERF_CNT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination of the load in EX
- mem_branch_taken  in  1  beq in MEM resolved taken
- halt_req  in  1  debug halt request, level
- pc_we  out  1  PC register write enable
- pc_src  out  1  1 = PC loads branch target
- pc_init  out  1  1 = PC loads RESET_VECTOR
- pc_init_val  out  32  constant RESET_VECTOR
- if_id_we  out  1  IF_ID write enable (0 = hold)
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all-zero) into register
- halt_ack  out  1  pipeline drained and frozen
- state  out  2  current FSM state (INIT=0, RUN=1, DRAIN=2, HALTED=3)
- stall_cnt, flush_cnt  out  CNT_W each  perf counters (HAZ_PERF_CNT_EN only)

## Operation
- FSM states: INIT, RUN, DRAIN, HALTED. The state register and counter are registered. Outputs are combinational from state and inputs.
- load_use = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- INIT behaviour:
  - Outputs: pc_init=1, pc_we=1, all four flushes=1, if_id_we=1, pc_src=0.
  - A counter runs from 0 to INIT_CYCLES-1, then the FSM goes to RUN.
  - Inputs are ignored.
- RUN outputs, in priority order:
  - branch: pc_we=1, pc_src=1, if_id_flush=id_ex_flush=ex_mem_flush=1.
  - else load_use: pc_we=0, if_id_we=0, id_ex_flush=1.
  - else normal: pc_we=1, if_id_we=1, no flush.
- RUN transitions: halt_req=1 → DRAIN, with the drain counter cleared. The current cycle's outputs are still RUN outputs.
- DRAIN behaviour:
  - Default outputs: pc_we=0, if_id_flush=1, which feeds bubbles behind the in-flight instructions.
  - On branch: the RUN branch outputs apply. The PC captures the target, so resume fetches the target. The counter advances.
  - On load_use: if_id_we=0, id_ex_flush=1, if_id_flush=0. The counter does not advance.
  - Counter reaching DRAIN_CYCLES-1 → HALTED.
  - halt_req dropping during DRAIN does not abort the drain.
- HALTED behaviour:
  - Outputs: halt_ack=1, pc_we=0, if_id_we=0, if_id_flush=1. Other flushes are 0; the stages already hold bubbles.
  - halt_req=0 → RUN next cycle.
- rst=1 in any state → INIT on the next edge; the counter clears.

## Timing
- Reset values: state=INIT, counters=0, halt_ack=0. Outputs during and immediately after reset equal the INIT outputs.
- First RUN cycle is INIT_CYCLES edges after rst deasserts.
- Load-use stall lasts exactly 1 cycle per hazard. The load advances to MEM, so load_use clears.
- Branch flush takes 1 cycle and squashes the 3 younger instructions. Fetch from the target begins the next cycle.
- halt_req asserted at edge n with no stalls in the drain → halt_ack=1 from cycle n+1+DRAIN_CYCLES. Each load-use stall in DRAIN adds 1 cycle.
- halt_ack falls in the same cycle the FSM leaves HALTED, i.e. 1 cycle after halt_req=0.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with a load_use stall applied.
  - flush_cnt increments on every branch flush.
  - Both counters saturate at all-ones and clear on rst.
- HAZ_PERF_CNT_EN undefined: both ports and their logic are absent.

## Structure
- Shared package mips_pipe_pkg holds the state enum (INIT/RUN/DRAIN/HALTED encodings) and the REG_ZERO=5'd0 constant.
- The load-use comparator is a combinational sub-module, load_use_detect. The FSM, counter and output decode stay in hazard_ctrl.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 → pc_init=1 and all flushes=1 for 4 cycles. state=RUN on the 5th cycle, with pc_we=1 and no flush.
- Load-use: ex_mem_read=1, ex_rt=2, id_rs=1, id_rt=2, id_uses_rt=1 → exactly 1 cycle of pc_we=0, if_id_we=0, id_ex_flush=1. stall_cnt=1. Same stimulus with ex_rt=0 → no stall.
- Branch + load-use in the same cycle → pc_src=1, pc_we=1, if_id/id_ex/ex_mem_flush=1, if_id_we=1. flush_cnt=1, stall_cnt unchanged.
- Halt: halt_req=1 in RUN with no hazards → 4 DRAIN cycles, halt_ack=1 on the 5th cycle. Dropping halt_req gives halt_ack=0 and RUN 1 cycle later.
- Halt with one load-use during DRAIN → halt_ack delayed to the 6th cycle. A branch during DRAIN → pc_src=1 pulse, and drain length unchanged.
- rst=1 mid-DRAIN → next cycle state=INIT, halt_ack=0, pc_init=1.
